alu_issue_unit: RTL

Sequencer that sits directly upstream of the team's combinational N-bit ALU. It accepts one instruction per handshake and reads two operands from an internal register file, or one operand plus an immediate. It drives the ALU's `a`, `b` and `ALUControl` inputs, then captures `Result`/`ALUFlags`, applies ARM-style conditional execution against a latched NZCV register, and writes the result back. Results and flags are also reported on an output strobe for downstream consumers.

---
 rtl/alu_issue_unit_if.sv | 53 +++++
 rtl/alu_issue_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit_if.sv
// Bundle of the instruction, register-load, ALU-side and completion signals
// exchanged between the issue unit (slave) and its environment (master).
interface alu_issue_unit_if #(
  parameter int N    = 4,
  parameter int NREG = 8
);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [3:0]    in_cond;
  logic          in_s;
  logic [RW-1:0] in_rd;
  logic [RW-1:0] in_rn;
  logic [RW-1:0] in_rm;
  logic          in_imm_en;
  logic [N-1:0]  in_imm;

  logic          ld_en;
  logic [RW-1:0] ld_addr;
  logic [N-1:0]  ld_data;

  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [3:0]    alu_ctrl;
  logic [N-1:0]  alu_result;
  logic [3:0]    alu_flags;

  logic          out_valid;
  logic          out_executed;
  logic [RW-1:0] out_rd;
  logic [N-1:0]  out_data;
  logic [3:0]    out_flags;

  modport slave (
    input  in_valid, in_op, in_cond, in_s, in_rd, in_rn, in_rm, in_imm_en, in_imm,
    input  ld_en, ld_addr, ld_data,
    input  alu_result, alu_flags,
    output in_ready,
    output alu_a, alu_b, alu_ctrl,
    output out_valid, out_executed, out_rd, out_data, out_flags
  );

  modport master (
    output in_valid, in_op, in_cond, in_s, in_rd, in_rn, in_rm, in_imm_en, in_imm,
    output ld_en, ld_addr, ld_data,
    output alu_result, alu_flags,
    input  in_ready,
    input  alu_a, alu_b, alu_ctrl,
    input  out_valid, out_executed, out_rd, out_data, out_flags
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Three-state issue sequencer for an external combinational ALU: register-file
// operand fetch, ARM-style conditional execution against NZCV, and writeback.
module alu_issue_unit #(
  parameter int N    = 4,
  parameter int NREG = 8
) (
  input  logic           clk,
  input  logic           reset,
  alu_issue_unit_if.slave bus
);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2} state_t;

  state_t        state_q;
  logic [3:0]    op_q, cond_q;
  logic          s_q, imm_en_q;
  logic [RW-1:0] rd_q, rn_q, rm_q;
  logic [N-1:0]  imm_q;
  logic [N-1:0]  rf_q [NREG];
  logic [3:0]    flags_q;
  logic          cond_pass_q;
  logic          in_ready_q, out_valid_q;
  logic [N-1:0]  alu_a_q, alu_b_q;
  logic [3:0]    alu_ctrl_q;
  logic [RW-1:0] out_rd_q;
  logic [N-1:0]  out_data_q;
  logic [3:0]    out_flags_q;
  logic          wb_en;
  logic [3:0]    flags_d;

  // Flags are ordered {V,N,Z,C}.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic v, n, z, cy;
    {v, n, z, cy} = f;
    case (c)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = !z;
      4'h2:    cond_eval = cy;
      4'h3:    cond_eval = !cy;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = !n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = !v;
      4'h8:    cond_eval = cy && !z;
      4'h9:    cond_eval = !cy || z;
      4'hA:    cond_eval = (n == v);
      4'hB:    cond_eval = (n != v);
      4'hC:    cond_eval = !z && (n == v);
      4'hD:    cond_eval = z || (n != v);
      default: cond_eval = 1'b1;
    endcase
  endfunction

  assign wb_en   = (state_q == EXEC) && cond_pass_q;
  assign flags_d = (wb_en && s_q) ? bus.alu_flags : flags_q;

  // Writeback is checked first so it overrides a colliding external load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && rd_q == RW'(i))
          rf_q[i] <= bus.alu_result;
        else if (bus.ld_en && bus.ld_addr == RW'(i))
          rf_q[i] <= bus.ld_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cond_q      <= '0;
      s_q         <= 1'b0;
      imm_en_q    <= 1'b0;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      imm_q       <= '0;
      flags_q     <= '0;
      cond_pass_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (bus.in_valid) begin
            op_q       <= bus.in_op;
            cond_q     <= bus.in_cond;
            s_q        <= bus.in_s;
            rd_q       <= bus.in_rd;
            rn_q       <= bus.in_rn;
            rm_q       <= bus.in_rm;
            imm_en_q   <= bus.in_imm_en;
            imm_q      <= bus.in_imm;
            in_ready_q <= 1'b0;
            state_q    <= READ;
          end
        end
        READ: begin
          alu_a_q     <= rf_q[rn_q];
          alu_b_q     <= imm_en_q ? imm_q : rf_q[rm_q];
          alu_ctrl_q  <= op_q;
          cond_pass_q <= cond_eval(cond_q, flags_q);
          out_rd_q    <= rd_q;
          out_valid_q <= 1'b1;
          state_q     <= EXEC;
        end
        EXEC: begin
          flags_q     <= flags_d;
          out_data_q  <= bus.alu_result;
          out_flags_q <= flags_d;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_ctrl     = alu_ctrl_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_executed = cond_pass_q;
  assign bus.out_rd       = out_rd_q;
  // Live ALU values while strobing; the last captured values otherwise.
  assign bus.out_data     = out_valid_q ? bus.alu_result : out_data_q;
  assign bus.out_flags    = out_valid_q ? flags_d : out_flags_q;
endmodule
